fiber_bus_initiator: RTL
========================

// Module: fiber_bus_initiator
// PURPOSE
// Host-side counterpart of the MPD fiber slave. Turns single-word command requests into
// FIBER_BUS register transactions (level RD/WR held until ACK, with timeout).
// Also receives the MPD event stream (WR/DATA/END) and forwards it to a downstream block
// FIFO with per-block word count and trailer check. Sits between the Aurora user
// interface and the host command/readout logic.
// PARAMETERS
// ACK_TIMEOUT  255  cycles in ACTIVE without BUS_ACK before the transaction aborts (>=4)
// GAP_CYCLES   2    cycles strobes are held low after a transaction (>=1)
// WCNT_W       16   width of block word counter
// PORTS
// CLK          in   1       system clock
// RSTb         in   1       asynchronous, active-low reset
// CMD_VALID    in   1       command request
// CMD_READY    out  1       command accepted when VALID&READY
// CMD_WR       in   1       1=write, 0=read
// CMD_ADDR     in   32      register address
// CMD_WDATA    in   32      write data
// RSP_VALID    out  1       1-cycle response pulse
// RSP_RDATA    out  32      read data (0 for writes, FFFFFFFF on timeout)
// RSP_TIMEOUT  out  1       response qualifier: transaction timed out
// BUS_ADDR     out  32      bus address, registered
// BUS_DOUT     out  32      bus write data, registered
// BUS_DIN      in   32      bus read data, valid while BUS_ACK=1
// BUS_WR       out  1       write strobe (level)
// BUS_RD       out  1       read strobe (level)
// BUS_ACK      in   1       slave acknowledge
// EVT_WR       in   1       event word write from MPD
// EVT_DATA     in   32      event word
// EVT_END      in   1       end-of-block marker write (data ignored)
// EVT_FULL     out  1       backpressure to MPD
// BLK_AFULL    in   1       downstream FIFO almost-full (>=2 words slack)
// BLK_WE       out  1       downstream write
// BLK_DATA     out  32      downstream data
// BLK_LAST     out  1       qualifies BLK_DATA as block trailer
// BLK_DONE     out  1       1-cycle pulse at block end
// BLK_WORDS    out  WCNT_W  word count of finished block (incl. trailer)
// BLK_ERR      out  1       finished block malformed; valid with BLK_DONE
// BEHAVIOUR
// Reset: all outputs 0, CMD_READY=0 during reset, FSM=IDLE, counters 0.
// FSM IDLE: CMD_READY=1. On CMD_VALID, latch ADDR/WDATA/WR into BUS_ADDR/BUS_DOUT,
//   assert BUS_WR or BUS_RD at next edge, clear timer, go ACTIVE.
// ACTIVE: CMD_READY=0, strobe held, timer+1 per cycle.
//   BUS_ACK=1: RSP_RDATA<=BUS_DIN (read) or 0 (write), RSP_VALID<=1, RSP_TIMEOUT<=0,
//   drop strobe, go GAP.
//   timer==ACK_TIMEOUT and no ACK: RSP_RDATA<=FFFFFFFF, RSP_TIMEOUT<=1, RSP_VALID<=1,
//   drop strobe, go GAP. ACK in the same cycle as expiry wins (normal response).
// GAP: strobes low for GAP_CYCLES, then IDLE. BUS_ACK outside ACTIVE is ignored.
// Nominal latency: strobe rises 1 cycle after accept; ACK returns 2 cycles later;
//   RSP_VALID 1 cycle after ACK.
// RSP_TIMEOUT and RSP_RDATA hold until the next response.
// Event path: EVT_FULL = BLK_AFULL (combinational).
// EVT_WR&~EVT_END: next edge BLK_WE=1, BLK_DATA=EVT_DATA,
//   BLK_LAST=(EVT_DATA[31:27]==5'b10001); count+1 (saturates at all-ones);
//   last_was_trailer<=BLK_LAST value.
// EVT_WR&EVT_END: next edge BLK_DONE=1, BLK_WORDS=count,
//   BLK_ERR=(count==0)|~last_was_trailer; count and last_was_trailer clear;
//   no BLK_WE for the END word.
// Paths are independent. Mid-operation reset aborts silently (no response); no partial
//   block is reported.
// TESTING
// Write 0x1234 to addr 0x100, slave ACK 2 cycles after WR rise -> BUS_WR high 3 cycles,
//   RSP_VALID, RSP_RDATA=0, RSP_TIMEOUT=0.
// Read addr 0x20, slave ACK with DIN=0xCAFE0001 -> RSP_RDATA=0xCAFE0001; RD low >=2 cycles
//   before next command strobe.
// Read with no ACK -> RSP_VALID at ACK_TIMEOUT+1 cycles after strobe rise,
//   RSP_TIMEOUT=1, RSP_RDATA=FFFFFFFF; late ACK ignored.
// Event block: 3 data words, trailer 0x88000003, END -> 4 BLK_WE, BLK_LAST on 4th,
//   BLK_DONE, BLK_WORDS=4, BLK_ERR=0.
// END with last data word not a trailer, and END with no data -> BLK_ERR=1, BLK_WORDS=2/0.
// BLK_AFULL=1 -> EVT_FULL=1 same cycle; RSTb low mid-transaction -> strobes, RSP_* and BLK_*
//   to 0 immediately.

Source files
------------

// File: rtl/fiber_bus_initiator.sv
// fiber_bus_initiator: host command to FIBER_BUS register transactions, plus MPD event stream to block FIFO
module fiber_bus_initiator #(
  parameter int ACK_TIMEOUT = 255,
  parameter int GAP_CYCLES  = 2,
  parameter int WCNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RSTb,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [31:0]       i_cmd_addr,
  input  logic [31:0]       i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_timeout,
  output logic [31:0]       o_bus_addr,
  output logic [31:0]       o_bus_dout,
  input  logic [31:0]       i_bus_din,
  output logic              o_bus_wr,
  output logic              o_bus_rd,
  input  logic              i_bus_ack,
  input  logic              i_evt_wr,
  input  logic [31:0]       i_evt_data,
  input  logic              i_evt_end,
  output logic              o_evt_full,
  input  logic              i_blk_afull,
  output logic              o_blk_we,
  output logic [31:0]       o_blk_data,
  output logic              o_blk_last,
  output logic              o_blk_done,
  output logic [WCNT_W-1:0] o_blk_words,
  output logic              o_blk_err
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;
  state_t r_state, w_state_nxt;
  logic [TW-1:0] r_tmr;
  logic r_run, r_rsp_valid, r_rsp_timeout, r_bus_wr, r_bus_rd;
  logic [31:0] r_rsp_rdata, r_bus_addr, r_bus_dout;
  logic w_accept, w_ack, w_tmo, w_gap_end;
  logic r_blk_we, r_blk_last, r_blk_done, r_blk_err, r_last_trl;
  logic [31:0] r_blk_data;
  logic [WCNT_W-1:0] r_cnt, r_blk_words;
  logic w_data_wr, w_end_wr, w_trl;

  // r_run keeps CMD_READY low until the first edge after reset release
  assign o_cmd_ready = r_run & (r_state == S_IDLE);
  assign w_accept    = i_cmd_valid & o_cmd_ready;
  assign w_ack       = (r_state == S_ACTIVE) & i_bus_ack;
  assign w_tmo       = (r_state == S_ACTIVE) & ~i_bus_ack & (r_tmr == TW'(ACK_TIMEOUT));
  assign w_gap_end   = (r_state == S_GAP) & (r_tmr == TW'(GAP_CYCLES - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_accept ? S_ACTIVE : S_IDLE;
      S_ACTIVE: w_state_nxt = (w_ack | w_tmo) ? S_GAP : S_ACTIVE;
      S_GAP:    w_state_nxt = w_gap_end ? S_IDLE : S_GAP;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb)
    if (!RSTb) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_run         <= 1'b0;
      r_tmr         <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_dout    <= '0;
      r_bus_wr      <= 1'b0;
      r_bus_rd      <= 1'b0;
    end else begin
      r_run       <= 1'b1;
      r_rsp_valid <= w_ack | w_tmo;
      if (w_accept) begin
        r_bus_addr <= i_cmd_addr;
        r_bus_dout <= i_cmd_wdata;
        r_bus_wr   <= i_cmd_wr;
        r_bus_rd   <= ~i_cmd_wr;
        r_tmr      <= '0;
      end else if (w_ack | w_tmo) begin
        r_rsp_rdata   <= w_ack ? (r_bus_rd ? i_bus_din : 32'h0) : 32'hFFFF_FFFF;
        r_rsp_timeout <= w_tmo;
        r_bus_wr      <= 1'b0;
        r_bus_rd      <= 1'b0;
        r_tmr         <= '0;
      end else if (r_state != S_IDLE) begin
        r_tmr <= r_tmr + 1'b1;
      end
    end
  end

  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_rdata   = r_rsp_rdata;
  assign o_rsp_timeout = r_rsp_timeout;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_dout    = r_bus_dout;
  assign o_bus_wr      = r_bus_wr;
  assign o_bus_rd      = r_bus_rd;

  assign o_evt_full = i_blk_afull;
  assign w_data_wr  = i_evt_wr & ~i_evt_end;
  assign w_end_wr   = i_evt_wr & i_evt_end;
  assign w_trl      = i_evt_data[31:27] == 5'b10001;

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      r_blk_we    <= 1'b0;
      r_blk_data  <= '0;
      r_blk_last  <= 1'b0;
      r_blk_done  <= 1'b0;
      r_blk_words <= '0;
      r_blk_err   <= 1'b0;
      r_cnt       <= '0;
      r_last_trl  <= 1'b0;
    end else begin
      r_blk_we   <= w_data_wr;
      r_blk_done <= w_end_wr;
      if (w_data_wr) begin
        r_blk_data <= i_evt_data;
        r_blk_last <= w_trl;
        r_last_trl <= w_trl;
        r_cnt      <= (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      end
      if (w_end_wr) begin
        r_blk_words <= r_cnt;
        r_blk_err   <= (r_cnt == '0) | ~r_last_trl;
        r_cnt       <= '0;
        r_last_trl  <= 1'b0;
      end
    end
  end

  assign o_blk_we    = r_blk_we;
  assign o_blk_data  = r_blk_data;
  assign o_blk_last  = r_blk_last;
  assign o_blk_done  = r_blk_done;
  assign o_blk_words = r_blk_words;
  assign o_blk_err   = r_blk_err;
endmodule
